// File: rtl/pad_config_loader.sv
// rtl/pad_config_loader.sv - serial shadow-chain loader driving the half-padframe configuration
module pad_config_loader #(
    parameter int                NPADS   = 46,
    parameter int                CFG_W   = 8,
    parameter logic [CFG_W-1:0]  DEF_CFG = 8'h0A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_sdi,
    output logic             cfg_ready,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_sdo,
    input  logic [NPADS-1:0] core_A,
    input  logic [NPADS-1:0] core_OE,
    output logic [NPADS-1:0] core_Y,
    output logic [NPADS-1:0] bidir_CS,
    output logic [NPADS-1:0] bidir_SL,
    output logic [NPADS-1:0] bidir_IE,
    output logic [NPADS-1:0] bidir_PU,
    output logic [NPADS-1:0] bidir_PD,
    output logic [NPADS-1:0] bidir_PDRV0,
    output logic [NPADS-1:0] bidir_PDRV1,
    output logic [NPADS-1:0] bidir_A,
    output logic [NPADS-1:0] bidir_OE,
    input  logic [NPADS-1:0] bidir_Y
);

    localparam int TOTAL = NPADS * CFG_W;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [TOTAL-1:0]   chain;
    logic [TOTAL-1:0]   active;
    logic               done_q;

    // A start in SHIFT takes priority over the bit offered in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = SHIFT;
            SHIFT:   if (!cfg_start && cfg_valid && count == LAST_BIT) state_next = APPLY;
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            chain  <= '0;
            active <= {NPADS{DEF_CFG}};
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == APPLY);
            case (state)
                IDLE: begin
                    if (cfg_start) count <= '0;
                end
                SHIFT: begin
                    if (cfg_start) begin
                        count <= '0;
                    end else if (cfg_valid) begin
                        chain <= {chain[TOTAL-2:0], cfg_sdi};
                        count <= count + CNT_W'(1);
                    end
                end
                APPLY: begin
                    active <= chain;
                end
                default: ;
            endcase
        end
    end

    assign cfg_ready = (state == SHIFT);
    assign cfg_busy  = (state != IDLE);
    assign cfg_done  = done_q;
    assign cfg_sdo   = chain[TOTAL-1];

    assign bidir_A = core_A;
    assign core_Y  = bidir_Y;

    // Word map: [7]PDRV1 [6]PDRV0 [5]SL [4]CS [3]PD [2]PU [1]IE [0]OEN
    for (genvar p = 0; p < NPADS; p++) begin : g_pad
        localparam int B = p * CFG_W;
        assign bidir_OE[p]    = core_OE[p] & active[B + 0];
        assign bidir_IE[p]    = active[B + 1];
        assign bidir_PU[p]    = active[B + 2];
        assign bidir_PD[p]    = active[B + 3];
        assign bidir_CS[p]    = active[B + 4];
        assign bidir_SL[p]    = active[B + 5];
        assign bidir_PDRV0[p] = active[B + 6];
        assign bidir_PDRV1[p] = active[B + 7];
    end

endmodule

// File: doc/pad_config_loader.md
Name: pad_config_loader

Overview:
- Core-side control stage that drives every configuration input of the 46 bidirectional pads in the half padframe: CS, SL, IE, PU, PD, PDRV0, PDRV1, and the OE/A pair.
- Per-pad configuration words arrive over a serial valid/ready stream into a shadow shift chain. The words are applied to all pads together in one cycle.
- Core data (A, OE) passes through to the pads, gated by a per-pad output-enable permission bit. Pad input data (Y) returns to the core unchanged.

Parameters:
- NPADS, 46, number of bidirectional pads controlled.
- CFG_W, 8, config bits per pad. Bit map: [7]PDRV1 [6]PDRV0 [5]SL [4]CS [3]PD [2]PU [1]IE [0]OEN. OEN=1 lets the core drive the pad.
- DEF_CFG, 8'h0A, per-pad reset configuration: IE=1, PD=1, all other bits 0.

Ports:
- clk  input  1  core clock, taken from the clock pad Y output.
- reset  input  1  synchronous, active-high.
- cfg_start  input  1  one-cycle pulse; arms a new load.
- cfg_valid  input  1  serial bit valid.
- cfg_sdi  input  1  serial config bit.
- cfg_ready  output  1  loader accepts a bit this cycle.
- cfg_busy  output  1  state is not IDLE.
- cfg_done  output  1  one-cycle pulse after the new configuration is applied.
- cfg_sdo  output  1  shadow chain MSB (chain[NPADS*CFG_W-1]).
- core_A  input  NPADS  core output data.
- core_OE  input  NPADS  core output-enable request.
- core_Y  output  NPADS  pad input data returned to the core.
- bidir_CS, bidir_SL, bidir_IE, bidir_PU, bidir_PD, bidir_PDRV0, bidir_PDRV1  output  NPADS each  registered per-pad configuration.
- bidir_A  output  NPADS  equals core_A.
- bidir_OE  output  NPADS  core_OE AND OEN.
- bidir_Y  input  NPADS  from the pads.

Behaviour:
- Storage:
  - TOTAL = NPADS*CFG_W (368 at defaults).
  - Shadow chain, TOTAL bits.
  - Active config register, NPADS x CFG_W.
  - Bit counter, clog2(TOTAL+1) bits (9 at defaults).
- Reset (synchronous):
  - State = IDLE, counter = 0, shadow chain = 0.
  - Every active word = DEF_CFG.
  - cfg_ready = 0, cfg_busy = 0, cfg_done = 0.
  - Resulting pad outputs: bidir_IE all 1, bidir_PD all 1, bidir_OE all 0, all other config outputs 0.
- IDLE:
  - cfg_ready = 0; cfg_valid is ignored.
  - cfg_start → SHIFT, counter cleared.
- SHIFT:
  - cfg_ready = 1.
  - Each cycle with cfg_valid=1: chain <= {chain[TOTAL-2:0], cfg_sdi}, counter += 1.
  - When the accepted bit is number TOTAL (counter == TOTAL-1 at that edge) → APPLY.
  - Bit order: the first bit transmitted lands in pad NPADS-1 bit CFG_W-1; the last bit lands in pad 0 bit 0. Pad p word = chain[p*CFG_W +: CFG_W].
  - cfg_start during SHIFT: restarts the load. Counter is cleared and state stays SHIFT. A bit presented in that same cycle is discarded.
- APPLY (single cycle):
  - cfg_ready = 0.
  - Active register <= chain; all pads change together on this edge.
  - Next state IDLE. cfg_done = 1 for exactly the cycle after APPLY.
  - cfg_start in APPLY is ignored.
- Latency: the last bit is accepted at edge N. New pad config is visible after edge N+1. cfg_done is high between edges N+1 and N+2.
- Data path (combinational, no latency):
  - bidir_A = core_A.
  - bidir_OE = core_OE & OEN.
  - core_Y = bidir_Y.
- Active config holds indefinitely between loads. A partial load never alters the active config.
- Reset mid-SHIFT: the partial load is discarded and the active config returns to DEF_CFG.
- cfg_busy = 1 in SHIFT and APPLY.

Test Plan:
1. Reset only → bidir_IE=46'h3FFF_FFFF_FFFF, bidir_PD=46'h3FFF_FFFF_FFFF, bidir_OE=0, bidir_CS=0; cfg_busy=0, cfg_ready=0.
2. cfg_start, then 368 bits encoding pad p word = p[7:0], cfg_valid held high → bidir_PU[2]=0, bidir_PU[5]=1 (word 8'h05), bidir_PDRV1[45]=0, bidir_CS[16]=1 (word 8'h10). cfg_done pulses exactly once, 2 cycles after the last bit is accepted.
3. Load with OEN=1 on pad 3 only; core_OE=all 1, core_A=46'h2AAA_AAAA_AAAA → bidir_OE=46'h8, bidir_A follows core_A with zero latency, core_Y mirrors bidir_Y.
4. Bits with random cfg_valid gaps (50% duty) → same final config as scenario 2; cfg_ready=1 throughout SHIFT, including during gaps.
5. Shift 100 bits, pulse cfg_start, then shift a full 368-bit stream → the active config reflects only the second stream. The active config is unchanged until that stream's APPLY.
6. Assert reset after 200 bits of a load that follows scenario 2's config → all active words = 8'h0A, state IDLE, no cfg_done pulse.
